// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV64M divider: FSM states, funct3
// encodings and iteration counts.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam int N_DWORD = 64;
    localparam int N_WORD  = 32;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] remNext,
    output logic [W-1:0] quoNext
);

    logic [W:0] trial;
    logic [W:0] diff;

    // trial < 2*divisor, so bit W of the difference is a clean borrow flag
    assign trial   = {rem, quo[W-1]};
    assign diff    = trial - {1'b0, divisor};
    assign remNext = diff[W] ? trial[W-1:0] : diff[W-1:0];
    assign quoNext = {quo[W-2:0], ~diff[W]};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU (and W-form) unit for the execute stage;
// holds the pipeline via stall_o until the registered result is ready.
module div_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic            is_word_op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    import div_pkg::*;

    localparam logic [5:0]      CNT_DWORD = 6'(N_DWORD - 1);
    localparam logic [5:0]      CNT_WORD  = 6'(N_WORD - 1);
    localparam logic [XLEN-1:0] DWORD_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] WORD_MIN  = {{(XLEN-31){1'b1}}, 31'b0};

    function automatic logic [XLEN-1:0] negateIf(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] wordExt(input logic [XLEN-1:0] v, input logic isWord);
        return isWord ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    div_state_t      state, stateNext;
    logic [XLEN-1:0] remReg, quoReg, divisorReg, resultReg;
    logic [XLEN-1:0] remNext, quoNext;
    logic [5:0]      stepCnt;
    logic            negQ, negR, remSel, wordOp;

    logic            isSigned, accept, divByZero, overflow, special;
    logic [XLEN-1:0] aExt, bExt, aMag, bMag, specialRes;
    logic            aNeg, bNeg;

    // Operand decode at the effective width, used only when accepting in IDLE
    assign isSigned = ~funct3_i[0];
    assign aExt = is_word_op_i ? {{(XLEN-32){isSigned & a_i[31]}}, a_i[31:0]} : a_i;
    assign bExt = is_word_op_i ? {{(XLEN-32){isSigned & b_i[31]}}, b_i[31:0]} : b_i;
    assign aNeg = isSigned & aExt[XLEN-1];
    assign bNeg = isSigned & bExt[XLEN-1];
    assign aMag = negateIf(aExt, aNeg);
    assign bMag = negateIf(bExt, bNeg);

    assign divByZero  = (bExt == '0);
    assign overflow   = isSigned && (bExt == '1) &&
                        (aExt == (is_word_op_i ? WORD_MIN : DWORD_MIN));
    assign special    = divByZero | overflow;
    assign specialRes = divByZero ? (funct3_i[1] ? aExt : '1)
                                  : (funct3_i[1] ? '0   : aExt);

    assign accept = (state == S_IDLE) && start_i && !flush_i;

    div_step #(.W(XLEN)) uStep (
        .rem     (remReg),
        .quo     (quoReg),
        .divisor (divisorReg),
        .remNext (remNext),
        .quoNext (quoNext)
    );

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (accept) stateNext = special ? S_DONE : S_CALC;
            S_CALC:  if (stepCnt == '0) stateNext = S_FIXUP;
            S_FIXUP: stateNext = S_DONE;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
        if (flush_i) stateNext = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            resultReg  <= '0;
            stepCnt    <= '0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
            remSel     <= 1'b0;
            wordOp     <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        negQ       <= aNeg ^ bNeg;
                        negR       <= aNeg;
                        remSel     <= funct3_i[1];
                        wordOp     <= is_word_op_i;
                        remReg     <= '0;
                        // W-form dividend sits in the top half so 32 steps consume it
                        quoReg     <= is_word_op_i ? {aMag[31:0], 32'b0} : aMag;
                        divisorReg <= bMag;
                        stepCnt    <= is_word_op_i ? CNT_WORD : CNT_DWORD;
                        if (special) resultReg <= wordExt(specialRes, is_word_op_i);
                    end
                end
                S_CALC: begin
                    remReg  <= remNext;
                    quoReg  <= quoNext;
                    stepCnt <= stepCnt - 6'd1;
                end
                S_FIXUP: begin
                    if (!flush_i)
                        resultReg <= wordExt(remSel ? negateIf(remReg, negR)
                                                    : negateIf(quoReg, negQ), wordOp);
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state == S_CALC) || (state == S_FIXUP);
    assign stall_o  = busy_o || accept;
    assign done_o   = (state == S_DONE);
    assign result_o = resultReg;

endmodule

// File: tb/tb_div_seq.sv
// Directed, table-driven checks of div_seq results, latency and handshake,
// plus hand-written flush and reset sequences.
module tb_div_seq;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, start_i, is_word_op_i, flush_i;
    logic [2:0]  funct3_i;
    logic [63:0] a_i, b_i;
    logic        stall_o, busy_o, done_o;
    logic [63:0] result_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  f3;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    div_seq #(.XLEN(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .funct3_i     (funct3_i),
        .is_word_op_i (is_word_op_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic doOp(input vec_t v);
        int   k;
        logic stallBad, busySeen;
        @(negedge clk);
        funct3_i     = v.f3;
        is_word_op_i = v.word;
        a_i          = v.a;
        b_i          = v.b;
        start_i      = 1'b1;
        #1 check({v.name, " stall@start"}, 64'(stall_o), 64'd1);
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        k        = 1;
        stallBad = 1'b0;
        busySeen = 1'b0;
        while (!done_o && k < 200) begin
            if (!stall_o) stallBad = 1'b1;
            if (busy_o) busySeen = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        check({v.name, " done"}, 64'(done_o), 64'd1);
        check({v.name, " latency"}, 64'(k), 64'(v.lat));
        check({v.name, " result"}, result_o, v.res);
        check({v.name, " stall@done"}, 64'(stall_o), 64'd0);
        check({v.name, " stall held"}, 64'(stallBad), 64'd0);
        check({v.name, " busy seen"}, 64'(busySeen), 64'(v.lat > 1));
        @(posedge clk);
        #1 check({v.name, " done pulse"}, 64'(done_o), 64'd0);
    endtask

    task automatic checkIdleZero(input string name);
        check({name, " stall"}, 64'(stall_o), 64'd0);
        check({name, " busy"}, 64'(busy_o), 64'd0);
        check({name, " done"}, 64'(done_o), 64'd0);
        check({name, " result"}, result_o, 64'd0);
    endtask

    initial begin
        vecs.push_back('{F3_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div -7/2"});
        vecs.push_back('{F3_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1, "remu /0"});
        vecs.push_back('{F3_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div ovf"});
        vecs.push_back('{F3_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem ovf"});
        vecs.push_back('{F3_DIVU, 1'b1, 64'hDEAD_BEEF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, "divuw"});
        vecs.push_back('{F3_REM,  1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, "remw -7/2"});
        vecs.push_back('{F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, "divu 100/7"});
        vecs.push_back('{F3_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "rem -7/2"});
        vecs.push_back('{F3_DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div 7/-2"});
        vecs.push_back('{F3_DIVU, 1'b0, '1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 66, "divu max/1"});
        vecs.push_back('{F3_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div /0"});
        vecs.push_back('{F3_REM,  1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, "rem -5/0"});
        vecs.push_back('{F3_DIV,  1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, "divw ovf"});
        vecs.push_back('{F3_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 34, "remuw"});
        vecs.push_back('{F3_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, "divuw sext"});
        vecs.push_back('{F3_REMU, 1'b0, 64'd1000, 64'h1_0000_0000, 64'd1000, 66, "remu big b"});
        vecs.push_back('{F3_DIV,  1'b1, -64'sd8, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFC, 34, "divw -8/2"});

        rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = F3_DIV; is_word_op_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1 checkIdleZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) doOp(vecs[i]);

        // Flush an unsigned divide ten cycles in
        @(negedge clk);
        funct3_i = F3_DIVU; is_word_op_i = 1'b0; a_i = 64'd100; b_i = 64'd7; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        #1 check("flush busy before", 64'(busy_o), 64'd1);
        @(posedge clk);
        #1;
        check("flush busy after", 64'(busy_o), 64'd0);
        check("flush done after", 64'(done_o), 64'd0);
        check("flush stall after", 64'(stall_o), 64'd0);
        flush_i = 1'b0;
        doOp('{F3_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, "after flush"});

        // start and flush together: nothing is latched
        @(negedge clk);
        funct3_i = F3_DIV; a_i = 64'd9; b_i = 64'd3; start_i = 1'b1; flush_i = 1'b1;
        #1 check("start+flush stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        check("start+flush busy", 64'(busy_o), 64'd0);
        check("start+flush done", 64'(done_o), 64'd0);
        start_i = 1'b0; flush_i = 1'b0;
        @(posedge clk);
        #1;
        check("start+flush done later", 64'(done_o), 64'd0);
        check("start+flush result held", result_o, 64'd14);

        // Reset twenty cycles into a signed divide
        @(negedge clk);
        funct3_i = F3_DIV; is_word_op_i = 1'b0; a_i = -64'sd7; b_i = 64'd2; start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 checkIdleZero("mid-op reset");
        rst_n = 1'b1;
        doOp('{F3_REM,  1'b0, 64'd100, 64'd7, 64'd2, 66, "post-reset rem"});
        doOp('{F3_DIVU, 1'b1, 64'd81, 64'd9, 64'd9, 34, "post-reset divuw"});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
